// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI packet path.
// Scheduler FSM encoding, packet flag bit positions and a saturating counter helper.
package mcu_spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WAIT_ACK = 2'd2,
    HOLDOFF  = 2'd3
  } sched_state_t;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int         FLAG_QV     = 0;
  localparam int         FLAG_GV     = 1;

  // Adds 0..2 events to an 8-bit count, sticking at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'b0000000, inc};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer for an asynchronous strobe, followed by a registered
// rising-edge detector producing a one-cycle pulse in the clk domain.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic pulse_r;

  // Synchronizer chain and edge-detect register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      prev_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      meta_r  <= async_in;
      sync_r  <= meta_r;
      prev_r  <= sync_r;
      pulse_r <= sync_r & ~prev_r;
    end
  end

  assign rise_pulse = pulse_r;

endmodule

// File: rtl/mcu_packet_scheduler.sv
// Merges quat/gyro sample pulses into a packet, publishes a frozen snapshot to the
// MCU SPI slave with a DONE/LOAD handshake, and counts samples lost to slow acknowledges.
module mcu_packet_scheduler
  import mcu_spi_pkg::*;
#(
  parameter int MERGE_CYCLES = 64,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        quat_valid,
  input  logic [63:0] quat_data,
  input  logic        gyro_valid,
  input  logic [47:0] gyro_data,
  input  logic        load,
  output logic        done,
  output logic [63:0] pkt_quat,
  output logic [47:0] pkt_gyro,
  output logic [7:0]  pkt_flags,
  output logic [7:0]  pkt_seq,
  output logic [7:0]  overrun_cnt
);

  localparam int TW = $clog2((MERGE_CYCLES > GAP_CYCLES) ? MERGE_CYCLES : GAP_CYCLES) + 1;
  localparam logic [TW-1:0] MERGE_LAST = TW'(MERGE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  sched_state_t  state_r;
  sched_state_t  state_nxt_s;
  logic [TW-1:0] timer_r;
  logic          sq_r;
  logic          sg_r;
  logic [63:0]   stage_quat_r;
  logic [47:0]   stage_gyro_r;
  logic          done_r;
  logic [63:0]   pkt_quat_r;
  logic [47:0]   pkt_gyro_r;
  logic [7:0]    pkt_flags_r;
  logic [7:0]    seq_r;
  logic [7:0]    overrun_r;
  logic          ack_s;
  logic          publish_s;
  logic          timer_clr_s;
  logic          timer_inc_s;
  logic          done_nxt_s;
  logic          quat_ovr_s;
  logic          gyro_ovr_s;
  logic [7:0]    flags_s;

  sync_rise_detect u_load_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (load),
    .rise_pulse (ack_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sq_r | sg_r) state_nxt_s = COLLECT;
        else             state_nxt_s = IDLE;
      end
      COLLECT: begin
        if ((sq_r & sg_r) || (timer_r == MERGE_LAST)) state_nxt_s = WAIT_ACK;
        else                                          state_nxt_s = COLLECT;
      end
      WAIT_ACK: begin
        if (ack_s) state_nxt_s = HOLDOFF;
        else       state_nxt_s = WAIT_ACK;
      end
      HOLDOFF: begin
        if (timer_r == GAP_LAST) begin
          if (sq_r | sg_r) state_nxt_s = COLLECT;
          else             state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLDOFF;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM control outputs; every state change restarts the shared timer.
  always_comb begin
    publish_s   = 1'b0;
    done_nxt_s  = 1'b0;
    timer_clr_s = (state_nxt_s != state_r);
    timer_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        done_nxt_s = 1'b0;
      end
      COLLECT: begin
        publish_s   = (state_nxt_s == WAIT_ACK);
        done_nxt_s  = publish_s;
        timer_inc_s = 1'b1;
      end
      WAIT_ACK: begin
        done_nxt_s = ~ack_s;
      end
      HOLDOFF: begin
        timer_inc_s = 1'b1;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Shared merge/holdoff timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (timer_clr_s) begin
      timer_r <= '0;
    end else if (timer_inc_s) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // A flag being cleared by this cycle's publish does not count as an overwrite.
  assign quat_ovr_s = quat_valid & sq_r & ~publish_s;
  assign gyro_ovr_s = gyro_valid & sg_r & ~publish_s;

  // Packet flag byte from the staging flags.
  always_comb begin
    flags_s          = 8'h00;
    flags_s[FLAG_QV] = sq_r;
    flags_s[FLAG_GV] = sg_r;
  end

  // Staging registers; a new sample always wins over the publish clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_r         <= 1'b0;
      sg_r         <= 1'b0;
      stage_quat_r <= 64'd0;
      stage_gyro_r <= 48'd0;
      overrun_r    <= 8'd0;
    end else begin
      if (quat_valid) begin
        stage_quat_r <= quat_data;
        sq_r         <= 1'b1;
      end else if (publish_s) begin
        sq_r <= 1'b0;
      end else begin
        sq_r <= sq_r;
      end
      if (gyro_valid) begin
        stage_gyro_r <= gyro_data;
        sg_r         <= 1'b1;
      end else if (publish_s) begin
        sg_r <= 1'b0;
      end else begin
        sg_r <= sg_r;
      end
      overrun_r <= sat_add8(overrun_r, {1'b0, quat_ovr_s} + {1'b0, gyro_ovr_s});
    end
  end

  // Published snapshot; only written on publish so it stays frozen through the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r      <= 1'b0;
      pkt_quat_r  <= 64'd0;
      pkt_gyro_r  <= 48'd0;
      pkt_flags_r <= 8'd0;
      seq_r       <= 8'd0;
    end else begin
      done_r <= done_nxt_s;
      if (publish_s) begin
        pkt_quat_r  <= stage_quat_r;
        pkt_gyro_r  <= stage_gyro_r;
        pkt_flags_r <= flags_s;
        seq_r       <= seq_r + 8'd1;
      end
    end
  end

  assign done        = done_r;
  assign pkt_quat    = pkt_quat_r;
  assign pkt_gyro    = pkt_gyro_r;
  assign pkt_flags   = pkt_flags_r;
  assign pkt_seq     = seq_r;
  assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_mcu_packet_scheduler.sv
// Bench for mcu_packet_scheduler: vector table, directed handshake/overrun/reset/wrap
// sequences and randomized traffic, all checked against a cycle-level reference model.
module tb_mcu_packet_scheduler;

  localparam int MERGE = 64;
  localparam int GAP   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        quat_valid;
  logic [63:0] quat_data;
  logic        gyro_valid;
  logic [47:0] gyro_data;
  logic        load;
  logic        done;
  logic [63:0] pkt_quat;
  logic [47:0] pkt_gyro;
  logic [7:0]  pkt_flags;
  logic [7:0]  pkt_seq;
  logic [7:0]  overrun_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mcu_packet_scheduler #(.MERGE_CYCLES(MERGE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .quat_valid(quat_valid), .quat_data(quat_data),
    .gyro_valid(gyro_valid), .gyro_data(gyro_data),
    .load(load), .done(done),
    .pkt_quat(pkt_quat), .pkt_gyro(pkt_gyro), .pkt_flags(pkt_flags),
    .pkt_seq(pkt_seq), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 merging, 2 awaiting ack, 3 gap.
  bit          m_sq, m_sg, m_done;
  logic [63:0] m_sq_d, m_pq;
  logic [47:0] m_sg_d, m_pg;
  logic [7:0]  m_pf, m_seq;
  int          m_ovr, m_mode, m_cnt;
  bit   [3:0]  hist;   // load as seen at the previous four edges, [0] most recent

  task automatic model_reset();
    m_sq = 0; m_sg = 0; m_done = 0; m_sq_d = '0; m_sg_d = '0; m_pq = '0; m_pg = '0;
    m_pf = '0; m_seq = '0; m_ovr = 0; m_mode = 0; m_cnt = 0; hist = '0;
  endtask

  task automatic model_edge();
    bit ack, pub, osq, osg;
    int n;
    ack  = hist[2] & ~hist[3];   // load rise seen 3 edges ago
    hist = {hist[2:0], load};
    osq = m_sq; osg = m_sg; pub = 0; n = 0;
    case (m_mode)
      0: if (osq || osg) begin m_mode = 1; m_cnt = 0; end
      1: if ((osq && osg) || m_cnt == MERGE - 1) pub = 1; else m_cnt++;
      2: if (ack) begin m_done = 0; m_mode = 3; m_cnt = 0; end
      3: if (m_cnt == GAP - 1) begin m_mode = (osq || osg) ? 1 : 0; m_cnt = 0; end else m_cnt++;
      default: m_mode = 0;
    endcase
    if (pub) begin
      m_pq = m_sq_d; m_pg = m_sg_d; m_pf = {6'b0, osg, osq};
      m_seq++; m_done = 1; m_mode = 2; m_sq = 0; m_sg = 0;
    end
    if (quat_valid) begin if (osq && !pub) n++; m_sq_d = quat_data; m_sq = 1; end
    if (gyro_valid) begin if (osg && !pub) n++; m_sg_d = gyro_data; m_sg = 1; end
    m_ovr = (m_ovr + n > 255) ? 255 : m_ovr + n;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("done", 64'(done), 64'(m_done));
    chk("pkt_quat", pkt_quat, m_pq);
    chk("pkt_gyro", 64'(pkt_gyro), 64'(m_pg));
    chk("pkt_flags", 64'(pkt_flags), 64'(m_pf));
    chk("pkt_seq", 64'(pkt_seq), 64'(m_seq));
    chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int c = 0; c < bound && !seen; c++) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    chk("wait_done_timeout", 64'(seen), 64'd1);
  endtask

  // Raise load and require done to drop exactly after the 4th edge, then sit out the gap.
  task automatic ack_check();
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ack_timing", 64'(done), (k < 3) ? 64'd1 : 64'd0);
    end
    load = 1'b0;
    repeat (GAP + 4) step();
  endtask

  task automatic send_pair(input logic [63:0] q, input logic [47:0] g);
    quat_valid = 1'b1; quat_data = q; gyro_valid = 1'b1; gyro_data = g;
    step();
    quat_valid = 1'b0; gyro_valid = 1'b0;
  endtask

  task automatic do_reset();
    quat_valid = 1'b0; gyro_valid = 1'b0; load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          gdelay;   // cycles after quat pulse for gyro pulse, -1 = none
    logic [63:0] qd;
    logic [47:0] gd;
    int          lat;      // edges after the quat edge until done is seen
    logic [7:0]  flags;
    logic [47:0] egyro;
  } vec_t;

  vec_t tv[5];

  initial begin
    int lat;
    tv[0] = '{-1, 64'h1111_2222_3333_4444, 48'hDEAD_BEEF_0000, 65, 8'h01, 48'h0};
    tv[1] = '{ 5, 64'hA0A1_A2A3_A4A5_A6A7, 48'h0102_0304_0506,  6, 8'h03, 48'h0102_0304_0506};
    tv[2] = '{ 0, 64'h8000_7FFF_FFFF_0001, 48'h7FFF_8000_FFFF,  2, 8'h03, 48'h7FFF_8000_FFFF};
    tv[3] = '{64, 64'h0F0F_F0F0_5555_AAAA, 48'h1234_5678_9ABC, 65, 8'h03, 48'h1234_5678_9ABC};
    tv[4] = '{65, 64'hCAFE_BABE_0BAD_F00D, 48'h4444_5555_6666, 65, 8'h01, 48'h1234_5678_9ABC};

    quat_valid = 1'b0; quat_data = '0; gyro_valid = 1'b0; gyro_data = '0; load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_seq", 64'(pkt_seq), 64'd0);
    chk("reset_flags", 64'(pkt_flags), 64'd0);
    chk("reset_ovr", 64'(overrun_cnt), 64'd0);
    chk("reset_quat", pkt_quat, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      lat = -1;
      for (int c = 0; c < 100 && lat < 0; c++) begin
        quat_valid = (c == 0); quat_data = tv[i].qd;
        gyro_valid = (c == tv[i].gdelay); gyro_data = tv[i].gd;
        step();
        if (done === 1'b1) lat = c;
      end
      quat_valid = 1'b0; gyro_valid = 1'b0;
      chk("tbl_latency", 64'(lat), 64'(tv[i].lat));
      chk("tbl_flags", 64'(pkt_flags), 64'(tv[i].flags));
      chk("tbl_quat", pkt_quat, tv[i].qd);
      chk("tbl_gyro", 64'(pkt_gyro), 64'(tv[i].egyro));
      chk("tbl_seq", 64'(pkt_seq), 64'(i + 1));
      chk("tbl_ovr", 64'(overrun_cnt), 64'd0);
      ack_check();
    end

    // Gyro that landed on the last publish edge goes out alone after the gap.
    wait_done(120);
    chk("late_gyro_flags", 64'(pkt_flags), 64'h02);
    chk("late_gyro_data", 64'(pkt_gyro), 64'h4444_5555_6666);
    chk("late_gyro_seq", 64'(pkt_seq), 64'd6);
    ack_check();

    // load activity while idle must be ignored.
    for (int k = 0; k < 3; k++) begin
      load = 1'b1; repeat (3) step();
      load = 1'b0; repeat (3) step();
    end
    repeat (4) step();
    chk("idle_load_done", 64'(done), 64'd0);
    chk("idle_load_seq", 64'(pkt_seq), 64'd6);

    // Three quat samples while waiting for ack: two overwrites, third sample published next.
    send_pair(64'h0123_4567_89AB_CDEF, 48'h5A5A_5A5A_5A5A);
    wait_done(10);
    for (int k = 0; k < 3; k++) begin
      quat_valid = 1'b1; quat_data = 64'hB000_0000_0000_0000 + 64'(k);
      step();
      quat_valid = 1'b0;
      step();
    end
    chk("ovr_three", 64'(overrun_cnt), 64'd2);
    chk("ovr_frozen", pkt_quat, 64'h0123_4567_89AB_CDEF);
    ack_check();
    wait_done(100);
    chk("ovr_third", pkt_quat, 64'hB000_0000_0000_0002);
    chk("ovr_seq", 64'(pkt_seq), 64'd8);

    // 300 writes during WAIT_ACK saturate the overrun counter.
    quat_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      quat_data = {$urandom, $urandom};
      step();
    end
    quat_valid = 1'b0;
    chk("ovr_saturate", 64'(overrun_cnt), 64'd255);
    ack_check();
    wait_done(100);
    ack_check();

    // Asynchronous reset in WAIT_ACK.
    send_pair(64'h7777_6666_5555_4444, 48'h3333_2222_1111);
    wait_done(10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_seq", 64'(pkt_seq), 64'd0);
    chk("async_rst_ovr", 64'(overrun_cnt), 64'd0);
    chk("async_rst_quat", pkt_quat, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_pair(64'h9999_8888_7777_6666, 48'hABCD_EF01_2345);
    wait_done(10);
    chk("post_rst_seq", 64'(pkt_seq), 64'd1);
    chk("post_rst_flags", 64'(pkt_flags), 64'h03);
    ack_check();

    // 256 packets from reset wrap the sequence number.
    do_reset();
    for (int p = 1; p <= 256; p++) begin
      send_pair({$urandom, $urandom}, 48'(p));
      wait_done(10);
      if (p == 255) chk("seq_255", 64'(pkt_seq), 64'd255);
      if (p == 256) chk("seq_wrap", 64'(pkt_seq), 64'd0);
      ack_check();
    end

    // Randomized traffic with asynchronous-looking load toggles.
    for (int c = 0; c < 4000; c++) begin
      quat_valid = ($urandom_range(0, 19) == 0);
      quat_data  = {$urandom, $urandom};
      gyro_valid = ($urandom_range(0, 23) == 0);
      gyro_data  = 48'({$urandom, $urandom});
      if ($urandom_range(0, 29) == 0) load = ~load;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
